// File: rtl/dpi_pattern_gen.sv
// Parallel-RGB (DPI) timing generator with four built-in test patterns,
// plus frame/second ticks and a seconds counter for board LEDs.
module dpi_pattern_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   BPC        = 6,
  parameter int   FPS        = 60,
  parameter int   CHECK_LOG2 = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [1:0]     mode,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [9:0]     x,
  output logic [9:0]     y,
  output logic [BPC-1:0] r,
  output logic [BPC-1:0] g,
  output logic [BPC-1:0] b,
  output logic           frame_tick,
  output logic           sec_tick,
  output logic [3:0]     sec_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int FW       = (FPS > 1) ? $clog2(FPS) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int BAR1     = H_ACTIVE / 3;
  localparam int BAR2     = (2 * H_ACTIVE) / 3;

  // Ramp divide by H_ACTIVE as multiply by a rounded-up reciprocal; 24 fraction
  // bits keep the truncation exact for any column below 1024.
  localparam int          RAMP_SHIFT = 24;
  localparam logic [47:0] RAMP_MUL   = ((48'd1 << (RAMP_SHIFT + BPC)) / 48'(H_ACTIVE)) + 48'd1;
  localparam logic [BPC-1:0] CMAX    = '1;

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [FW-1:0]  frame_cnt;
  logic [1:0]     mode_q;
  logic           sec_wrap;

  logic           frame_start;
  logic           line_end;
  logic           frame_end;
  logic [1:0]     mode_eff;
  logic           active;
  logic           hs_act;
  logic           vs_act;
  logic [10:0]    hx;
  logic [10:0]    vy;
  logic [10:0]    scroll_x;
  logic           check_on;
  logic [47:0]    ramp_prod;
  logic [47:0]    ramp_full;
  logic [BPC-1:0] ramp;
  logic [BPC-1:0] r_next;
  logic [BPC-1:0] g_next;
  logic [BPC-1:0] b_next;
  logic           unused_bits;

  // The frame-start pixel already uses the freshly sampled mode so a whole frame is uniform.
  always_comb begin
    frame_start = (h_cnt == '0) && (v_cnt == '0);
    line_end    = (h_cnt == HW'(H_TOTAL - 1));
    frame_end   = line_end && (v_cnt == VW'(V_TOTAL - 1));
    mode_eff    = frame_start ? mode : mode_q;
    active      = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hs_act      = (h_cnt >= HW'(HS_START)) && (h_cnt <= HW'(HS_LAST));
    vs_act      = (v_cnt >= VW'(VS_START)) && (v_cnt <= VW'(VS_LAST));
    hx          = 11'(h_cnt);
    vy          = 11'(v_cnt);
    scroll_x    = hx + 11'(frame_cnt);
    check_on    = ((mode_eff == 2'd3) ? scroll_x[CHECK_LOG2] : hx[CHECK_LOG2]) ^ vy[CHECK_LOG2];
    ramp_prod   = 48'(hx) * RAMP_MUL;
    ramp_full   = ramp_prod >> RAMP_SHIFT;
    ramp        = (ramp_full > 48'(CMAX)) ? CMAX : BPC'(ramp_full);
    unused_bits = ^{vy, scroll_x};

    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (active) begin
      case (mode_eff)
        2'd0, 2'd3: begin
          r_next = CMAX;
          if (check_on) begin
            g_next = CMAX;
            b_next = CMAX;
          end
        end
        2'd1: begin
          if (h_cnt < HW'(BAR1)) begin
            r_next = CMAX;
          end else if (h_cnt < HW'(BAR2)) begin
            r_next = CMAX;
            g_next = CMAX;
            b_next = CMAX;
          end else begin
            b_next = CMAX;
          end
        end
        2'd2: begin
          r_next = ramp;
          g_next = ramp;
          b_next = ramp;
        end
      endcase
    end
  end

  // sec_wrap is high exactly during the first counter cycle of a frame that wrapped frame_cnt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      mode_q    <= 2'd0;
      sec_wrap  <= 1'b0;
    end else begin
      h_cnt    <= line_end ? '0 : h_cnt + 1'b1;
      sec_wrap <= frame_end && (frame_cnt == FW'(FPS - 1));
      if (line_end) begin
        v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
      end
      if (frame_end) begin
        frame_cnt <= (frame_cnt == FW'(FPS - 1)) ? '0 : frame_cnt + 1'b1;
      end
      if (frame_start) begin
        mode_q <= mode;
      end
    end
  end

  // All pins register the current counter state, so every output lags it by one clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      de         <= 1'b0;
      x          <= '0;
      y          <= '0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
      frame_tick <= 1'b0;
      sec_tick   <= 1'b0;
      sec_count  <= '0;
    end else begin
      hsync      <= hs_act ? HS_POL : ~HS_POL;
      vsync      <= vs_act ? VS_POL : ~VS_POL;
      de         <= active;
      x          <= active ? 10'(h_cnt) : '0;
      y          <= active ? 10'(v_cnt) : '0;
      r          <= r_next;
      g          <= g_next;
      b          <= b_next;
      frame_tick <= frame_start;
      sec_tick   <= sec_wrap;
      if (sec_wrap) begin
        sec_count <= sec_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dpi_pattern_gen.sv
// Scoreboard bench for dpi_pattern_gen: a cycle-position reference model queues
// the expected pins for every clock, a monitor pops and compares them.
module tb_dpi_pattern_gen;

  localparam int H_ACTIVE = 60, H_FP = 4, H_SYNC = 8, H_BP = 8;
  localparam int V_ACTIVE = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b1;
  localparam int BPC = 6, FPS = 2, CHECK_LOG2 = 3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int F_TOTAL = H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic           hsync;
    logic           vsync;
    logic           de;
    logic [9:0]     x;
    logic [9:0]     y;
    logic [BPC-1:0] r;
    logic [BPC-1:0] g;
    logic [BPC-1:0] b;
    logic           frame_tick;
    logic           sec_tick;
    logic [3:0]     sec_count;
  } pix_t;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic           hsync, vsync, de, frame_tick, sec_tick;
  logic [9:0]     x, y;
  logic [BPC-1:0] r, g, b;
  logic [3:0]     sec_count;

  pix_t       exp_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  logic [1:0] frame_mode = 2'd0;

  dpi_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .BPC(BPC), .FPS(FPS), .CHECK_LOG2(CHECK_LOG2)
  ) dut (
    .clk(clk), .resetn(resetn), .mode(mode),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .r(r), .g(g), .b(b),
    .frame_tick(frame_tick), .sec_tick(sec_tick), .sec_count(sec_count)
  );

  always #5 clk = ~clk;

  // Expected pins for the n-th clock after reset release, from raster position alone.
  function automatic pix_t ref_pixel(int n, logic [1:0] fmode);
    pix_t e;
    int p, h, v, f, fc, cx, cmax, gray;
    bit cb;
    p    = n % F_TOTAL;
    h    = p % H_TOTAL;
    v    = p / H_TOTAL;
    f    = n / F_TOTAL;
    fc   = f % FPS;
    cmax = (1 << BPC) - 1;
    e = '0;
    e.hsync      = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : !HS_POL;
    e.vsync      = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : !VS_POL;
    e.frame_tick = (p == 0);
    e.sec_tick   = (p == 0) && (f > 0) && (fc == 0);
    e.sec_count  = 4'((f / FPS) % 16);
    if (h < H_ACTIVE && v < V_ACTIVE) begin
      e.de = 1'b1;
      e.x  = 10'(h);
      e.y  = 10'(v);
      if (fmode == 2'd1) begin
        if (h < H_ACTIVE / 3) e.r = BPC'(cmax);
        else if (h < (2 * H_ACTIVE) / 3) begin
          e.r = BPC'(cmax); e.g = BPC'(cmax); e.b = BPC'(cmax);
        end else e.b = BPC'(cmax);
      end else if (fmode == 2'd2) begin
        gray = (h * (1 << BPC)) / H_ACTIVE;
        e.r = BPC'(gray); e.g = BPC'(gray); e.b = BPC'(gray);
      end else begin
        cx = (fmode == 2'd3) ? h + fc : h;
        cb = (((cx >> CHECK_LOG2) & 1) != ((v >> CHECK_LOG2) & 1));
        e.r = BPC'(cmax);
        if (cb) begin
          e.g = BPC'(cmax); e.b = BPC'(cmax);
        end
      end
    end
    return e;
  endfunction

  // Reference model: one expected entry per clock while out of reset.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc = 0;
      exp_q.delete();
    end else begin
      if (cyc % F_TOTAL == 0) frame_mode = mode;
      exp_q.push_back(ref_pixel(cyc, frame_mode));
      cyc = cyc + 1;
    end
  end

  task automatic check_output(input string name, input pix_t got, input pix_t want);
    tests_run = tests_run + 1;
    if (got !== want) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  // Monitor: reset values while held in reset, scoreboard entries otherwise.
  initial begin
    pix_t got;
    pix_t rst_val;
    rst_val = '0;
    rst_val.hsync = !HS_POL;
    rst_val.vsync = !VS_POL;
    forever begin
      @(posedge clk or negedge resetn);
      #1;
      got = {hsync, vsync, de, x, y, r, g, b, frame_tick, sec_tick, sec_count};
      if (!resetn) begin
        check_output("reset_state", got, rst_val);
      end else if (exp_q.size() == 0) begin
        tests_run = tests_run + 1;
        tests_failed = tests_failed + 1;
        $display("[TB] FAIL scoreboard_empty at t=%0t: got %h, expected an entry", $time, got);
      end else begin
        check_output("pixel", got, exp_q.pop_front());
      end
    end
  end

  // Switches mode mid-frame every frame, plus occasional random extra switches.
  task automatic apply_stimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (i % F_TOTAL == 7 * H_TOTAL + 13) mode = 2'((i / F_TOTAL) % 4);
      else if ($urandom_range(0, 499) == 0) mode = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    apply_stimulus(34 * F_TOTAL + 100);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    apply_stimulus(3 * F_TOTAL);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
